// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-unit state encoding, opcode constants and the
// 6502 instruction-length decode used by the fetch unit.
package cpu_pkg;

  localparam int IFU_ADDR_W = 16;

  typedef enum logic [2:0] {
    IFU_IDLE,
    IFU_REQ_OPC,
    IFU_REQ_OP1,
    IFU_REQ_OP2,
    IFU_DONE
  } ifu_state_t;

  localparam logic [7:0] OPC_BRK = 8'h00;
  localparam logic [7:0] OPC_JSR = 8'h20;
  localparam logic [7:0] OPC_RTI = 8'h40;
  localparam logic [7:0] OPC_RTS = 8'h60;

  // Total bytes (opcode + operands) for a 6502 opcode, range 1..3.
  function automatic logic [1:0] instr_length(input logic [7:0] opc);
    if (opc == OPC_BRK || opc == OPC_RTI || opc == OPC_RTS ||
        opc[3:0] == 4'h8 || opc[3:0] == 4'hA)
      return 2'd1;
    else if (opc == OPC_JSR || opc[3:2] == 2'b11 || opc[4:0] == 5'b11001)
      return 2'd3;
    else
      return 2'd2;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetches one complete 6502 instruction over a registered req/ack byte interface.
// Optional `IFU_WAIT_TIMEOUT_EN: abort a request after TIMEOUT_CYC unacked cycles.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = IFU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_enable,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        opcode,
  output logic [15:0]       operand,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fetch_done,
  output logic              fetch_error
);

  if (TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYC must be at least 1");
  end

  ifu_state_t state, state_nx;
  logic       byte_ok;
  logic       timeout;
  logic       req_nx;
  logic [1:0] len_nx;

  // mem_req is only ever high in the REQ_* states, so an ack is meaningful there only.
  assign byte_ok = mem_req & mem_ack;
  assign len_nx  = instr_length(mem_rdata);
  assign req_nx  = (state_nx == IFU_REQ_OPC) || (state_nx == IFU_REQ_OP1) ||
                   (state_nx == IFU_REQ_OP2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IFU_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IFU_IDLE:    if (fetch_enable) state_nx = IFU_REQ_OPC;
      IFU_REQ_OPC: if (timeout) state_nx = IFU_DONE;
                   else if (byte_ok) state_nx = (len_nx == 2'd1) ? IFU_DONE : IFU_REQ_OP1;
      IFU_REQ_OP1: if (timeout) state_nx = IFU_DONE;
                   else if (byte_ok) state_nx = (instr_len == 2'd3) ? IFU_REQ_OP2 : IFU_DONE;
      IFU_REQ_OP2: if (timeout || byte_ok) state_nx = IFU_DONE;
      IFU_DONE:    state_nx = IFU_IDLE;
      default:     state_nx = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC;
      opcode     <= '0;
      operand    <= '0;
      instr_len  <= 2'd1;
      busy       <= 1'b0;
      fetch_done <= 1'b0;
    end else begin
      mem_req    <= req_nx;
      busy       <= req_nx;
      fetch_done <= (state == IFU_DONE);
      if (state == IFU_IDLE) begin
        if (pc_load) pc <= pc_load_value;
        if (fetch_enable) mem_addr <= pc_load ? pc_load_value : pc;
      end
      if (byte_ok) begin
        pc       <= pc + 1'b1;
        mem_addr <= mem_addr + 1'b1;
        unique case (state)
          IFU_REQ_OPC: begin
            opcode    <= mem_rdata;
            operand   <= '0;
            instr_len <= len_nx;
          end
          IFU_REQ_OP1: operand[7:0]  <= mem_rdata;
          IFU_REQ_OP2: operand[15:8] <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

`ifdef IFU_WAIT_TIMEOUT_EN
  logic [15:0] wait_cnt;

  assign timeout = mem_req && !mem_ack && (wait_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      fetch_error <= 1'b0;
    end else begin
      if (state == IFU_IDLE || byte_ok) wait_cnt <= '0;
      else if (mem_req && !mem_ack)     wait_cnt <= wait_cnt + 1'b1;
      if (timeout) fetch_error <= 1'b1;
    end
  end
`else
  assign timeout     = 1'b0;
  assign fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a byte-memory model with
// variable ack latency; the timeout scenario runs when IFU_WAIT_TIMEOUT_EN is defined.
module tb_instruction_fetch_unit;

  localparam int          TMO = 16;
  localparam logic [15:0] RPC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_enable, pc_load;
  logic [15:0] pc_load_value;
  logic        mem_req, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  opcode;
  logic [15:0] operand;
  logic [1:0]  instr_len;
  logic [15:0] pc;
  logic        busy, fetch_done, fetch_error;

  instruction_fetch_unit #(.ADDR_W(16), .RESET_PC(RPC), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_enable(fetch_enable), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .opcode(opcode), .operand(operand),
    .instr_len(instr_len), .pc(pc), .busy(busy), .fetch_done(fetch_done),
    .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction length from the 6502 opcode-map rules.
  function automatic int ilen_ref(input logic [7:0] opc);
    if (opc inside {8'h00, 8'h40, 8'h60} || opc[3:0] inside {4'h8, 4'hA}) return 1;
    if (opc == 8'h20 || (opc & 8'h0C) == 8'h0C || (opc & 8'h1F) == 8'h19) return 3;
    return 2;
  endfunction

  logic [7:0]  mem [0:65535];
  logic [15:0] addr_log [$];
  int          min_dly = 0, max_dly = 0;
  bit          no_ack = 1'b0;
  bit          exp_err = 1'b0;
  logic [15:0] model_pc;

  // Memory responder: random wait states per request, spurious acks while idle.
  initial begin
    int          wait_left;
    bit          holding;
    logic [15:0] held_addr;
    mem_ack = 1'b0; mem_rdata = '0; wait_left = 0; holding = 1'b0; held_addr = '0;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        holding   = 1'b0;
        wait_left = $urandom_range(max_dly, min_dly);
        mem_ack   = 1'($urandom_range(1, 0));
        mem_rdata = 8'($urandom);
      end else begin
        if (holding) check("addr_stable", mem_addr, held_addr);
        if (!no_ack && wait_left == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          addr_log.push_back(mem_addr);
          holding   = 1'b0;
          wait_left = $urandom_range(max_dly, min_dly);
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 8'($urandom);
          holding   = 1'b1;
          held_addr = mem_addr;
          if (wait_left > 0) wait_left--;
        end
      end
    end
  end

  task automatic do_fetch(input bit load, input logic [15:0] lval, input bit inject,
                          input bit chk_lat);
    logic [15:0] start, a, exp_opnd;
    logic [15:0] exp_addr [$];
    int          len, cycles;
    bit          seen;
    start = load ? lval : model_pc;
    len   = ilen_ref(mem[start]);
    exp_opnd = '0;
    for (int k = 0; k < len; k++) begin
      a = start + 16'(k);
      exp_addr.push_back(a);
      if (k == 1) exp_opnd[7:0]  = mem[a];
      if (k == 2) exp_opnd[15:8] = mem[a];
    end
    addr_log.delete();
    @(negedge clk);
    fetch_enable = 1'b1; pc_load = load; pc_load_value = lval;
    cycles = 0; seen = 1'b0;
    while (cycles < 300 && !seen) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        fetch_enable = 1'b0; pc_load = 1'b0;
        check("busy_start", busy, 1);
      end
      if (inject && cycles == 2) begin
        fetch_enable = 1'b1; pc_load = 1'b1; pc_load_value = 16'($urandom);
      end
      if (inject && cycles == 3) begin
        fetch_enable = 1'b0; pc_load = 1'b0;
      end
      if (fetch_done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    if (chk_lat) check("latency", cycles, len + 2);
    check("opcode", opcode, mem[start]);
    check("operand", operand, exp_opnd);
    check("instr_len", instr_len, len);
    check("pc", pc, 16'(start + 16'(len)));
    check("busy_end", busy, 0);
    check("fetch_error", fetch_error, exp_err);
    check("addr_cnt", addr_log.size(), len);
    for (int k = 0; k < len && k < addr_log.size(); k++) check("addr_seq", addr_log[k], exp_addr[k]);
    @(negedge clk);
    check("done_pulse", fetch_done, 0);
    model_pc = start + 16'(len);
  endtask

  initial begin
    reset_n = 1'b0; fetch_enable = 1'b0; pc_load = 1'b0; pc_load_value = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    model_pc = RPC;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, RPC);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, RPC);
    check("rst_opcode", opcode, 0);
    check("rst_operand", operand, 0);
    check("rst_len", instr_len, 1);
    check("rst_busy", busy, 0);
    check("rst_done", fetch_done, 0);
    check("rst_err", fetch_error, 0);
    reset_n = 1'b1;

    // LDA #imm at 0000, zero-wait memory
    mem[16'h0000] = 8'hA9; mem[16'h0001] = 8'h42;
    do_fetch(1'b0, '0, 1'b0, 1'b1);
    check("t1_operand", operand, 16'h0042);
    check("t1_pc", pc, 16'h0002);

    // JMP abs loaded at FFFE, wraps through 0000
    mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
    do_fetch(1'b1, 16'hFFFE, 1'b0, 1'b1);
    check("t2_operand", operand, 16'h1234);
    check("t2_pc", pc, 16'h0001);

    // pc_load alone in IDLE, then NOP with three wait states
    @(negedge clk); pc_load = 1'b1; pc_load_value = 16'h0300;
    @(negedge clk); pc_load = 1'b0;
    check("t3_load", pc, 16'h0300);
    model_pc = 16'h0300;
    mem[16'h0300] = 8'hEA;
    min_dly = 3; max_dly = 3;
    do_fetch(1'b0, '0, 1'b0, 1'b0);

    // LDA abs with fetch_enable/pc_load pulsed during REQ_OP1
    min_dly = 0; max_dly = 0;
    mem[16'h0301] = 8'hAD; mem[16'h0302] = 8'h34; mem[16'h0303] = 8'h12;
    do_fetch(1'b0, '0, 1'b1, 1'b1);
    check("t4_pc", pc, 16'h0304);

    // Reset asserted while waiting on the second operand byte
    mem[16'h0304] = 8'h20;
    @(negedge clk); fetch_enable = 1'b1;
    @(negedge clk); fetch_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_req_before", mem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_req", mem_req, 0);
    check("t5_pc", pc, RPC);
    check("t5_busy", busy, 0);
    check("t5_opcode", opcode, 0);
    @(negedge clk); reset_n = 1'b1;
    model_pc = RPC;
    do_fetch(1'b0, '0, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      max_dly = $urandom_range(2, 0);
      min_dly = 0;
      do_fetch(($urandom_range(3, 0) == 0), 16'($urandom), 1'($urandom_range(1, 0)),
               (max_dly == 0));
    end

`ifdef IFU_WAIT_TIMEOUT_EN
    begin
      logic [15:0] start;
      logic [7:0]  prev_opc;
      int          cycles;
      bit          seen;
      start = model_pc; prev_opc = opcode; no_ack = 1'b1;
      @(negedge clk); fetch_enable = 1'b1;
      cycles = 0; seen = 1'b0;
      while (cycles < 300 && !seen) begin
        @(negedge clk);
        cycles++;
        if (cycles == 1) fetch_enable = 1'b0;
        if (fetch_done) seen = 1'b1;
      end
      check("tmo_done", seen, 1);
      check("tmo_latency", cycles, TMO + 2);
      check("tmo_err", fetch_error, 1);
      check("tmo_pc", pc, start);
      check("tmo_opcode", opcode, prev_opc);
      check("tmo_req", mem_req, 0);
      no_ack = 1'b0; exp_err = 1'b1;
      do_fetch(1'b0, '0, 1'b0, 1'b0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Responder to the control sequencer's fetch stage. On a fetch_enable pulse it reads one complete 6502 instruction (opcode plus 0–2 operand bytes) from byte memory over a req/ack handshake.
- Advances the program counter and returns the opcode to the sequencer. Sits between the sequencer and the memory interface; feeds decode.

Parameters:
- ADDR_W, 16, program counter / memory address width
- RESET_PC, 16'h0000, PC value loaded on reset
- TIMEOUT_CYC, 16, max cycles to wait for mem_ack (used only with IFU_WAIT_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- fetch_enable  in  1  start request from sequencer; sampled only in IDLE
- pc_load  in  1  load new PC (jump/branch/vector); honoured only in IDLE
- pc_load_value  in  ADDR_W  PC value for pc_load
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  read address, stable while mem_req high
- mem_ack  in  1  read data valid for current request
- mem_rdata  in  8  read data
- opcode  out  8  fetched opcode
- operand  out  16  operand bytes, little-endian; unused bytes zero
- instr_len  out  2  instruction length 1..3
- pc  out  ADDR_W  current program counter
- busy  out  1  fetch in progress
- fetch_done  out  1  one-cycle pulse: instruction complete
- fetch_error  out  1  sticky timeout flag (0 when feature absent)

Behaviour:
- Reset: state IDLE; pc=RESET_PC; mem_req=0; mem_addr=RESET_PC; opcode=0; operand=0; instr_len=1; busy=0; fetch_done=0; fetch_error=0.
- States: IDLE, REQ_OPC, REQ_OP1, REQ_OP2, DONE.
- IDLE:
  - pc_load=1 → pc<=pc_load_value.
  - fetch_enable=1 → REQ_OPC; busy=1; mem_req=1; mem_addr=pc, or pc_load_value if pc_load is in the same cycle (load wins, fetch uses the new PC).
- Handshake: mem_req and mem_addr are registered. A byte is captured on any cycle with mem_req && mem_ack.
  - If another byte is needed, the next cycle keeps mem_req=1 with mem_addr+1.
  - Otherwise mem_req drops the next cycle.
  - mem_ack while mem_req=0 is ignored.
- REQ_OPC on ack: opcode<=mem_rdata; operand<=0; instr_len<=ilen(mem_rdata); pc<=pc+1.
  - Length 1 → DONE; else → REQ_OP1.
- REQ_OP1 on ack: operand[7:0]<=mem_rdata; pc<=pc+1. Length 3 → REQ_OP2; else → DONE.
- REQ_OP2 on ack: operand[15:8]<=mem_rdata; pc<=pc+1; → DONE.
- DONE: fetch_done=1 for exactly one cycle; busy=0; → IDLE. Outputs are held until the next fetch captures a new opcode.
- Latency with zero-wait memory (ack in the first req cycle): fetch_enable at cycle 0 → mem_req at cycle 1 → fetch_done at cycle 1+len+1 (len 3 → cycle 5).
- ilen rule:
  - 1 if opcode in {00,40,60} or low nibble is 8 or A.
  - 3 if opcode==20, or opcode[3:2]==2'b11, or opcode[4:0]==5'b11001.
  - 2 otherwise.
- PC arithmetic is modulo 2^ADDR_W: FFFF+1 → 0000. The address increment wraps the same way.
- fetch_enable or pc_load while busy: ignored, no queuing.
- reset_n low mid-fetch: immediate return to reset values; mem_req drops asynchronously.

Optional Feature:
- Macro: IFU_WAIT_TIMEOUT_EN.
- Defined:
  - A wait counter clears on each new request and counts cycles with mem_req && !mem_ack.
  - When it reaches TIMEOUT_CYC: fetch_error<=1 (sticky until reset), mem_req<=0, PC unchanged from the last accepted byte, → DONE (fetch_done still pulses).
- Undefined: no counter; waits forever; fetch_error tied 0.

Decomposition:
- Shared package cpu_pkg:
  - ifu_state_t enum.
  - ADDR_W default.
  - Opcode constants OPC_BRK=8'h00, OPC_JSR=8'h20, OPC_RTI=8'h40, OPC_RTS=8'h60.
  - Function instr_length(opcode) → 2-bit length.
- Sub-module: none. Length decode is the package function; the FSM and datapath stay in one module.

Test Plan:
- Reset then fetch at PC 0000, mem holds A9 42, zero-wait → opcode=A9, operand=0042, instr_len=2, pc=0002, fetch_done pulse at cycle 4.
- pc_load=1, pc_load_value=FFFE together with fetch_enable; mem FFFE=4C, FFFF=34, 0000=12 → addresses FFFE,FFFF,0000; operand=1234; pc=0001.
- Opcode EA with mem_ack delayed 3 cycles → mem_req/mem_addr stable 4 cycles; len 1; one byte read; pc +1; fetch_done once.
- fetch_enable and pc_load pulsed during REQ_OP1 → ignored; pc and request sequence unchanged.
- reset_n low during REQ_OP2 → mem_req=0 immediately; pc=RESET_PC; state IDLE; the next fetch starts clean.
- With IFU_WAIT_TIMEOUT_EN, no ack → fetch_error=1 after 16 wait cycles, fetch_done pulses, pc unchanged.
